// File: rtl/vga_frame_timing.sv
// Raster timing generator: beam position, visible flag, syncs, per-frame update strobe
// and a free-running frame counter, all registered and advancing on pixel_ce_i.
module vga_frame_timing #(
    parameter int unsigned H_VISIBLE        = 800,
    parameter int unsigned H_FRONT          = 40,
    parameter int unsigned H_SYNC           = 128,
    parameter int unsigned H_BACK           = 88,
    parameter int unsigned V_VISIBLE        = 600,
    parameter int unsigned V_FRONT          = 1,
    parameter int unsigned V_SYNC           = 4,
    parameter int unsigned V_BACK           = 23,
    parameter int unsigned SYNC_ACTIVE_HIGH = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pixel_ce_i,
    output logic [10:0] x_pixel_o,
    output logic [9:0]  y_pixel_o,
    output logic        visible_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        start_update_o,
    output logic [15:0] frame_count_o
);

    localparam int unsigned X_W      = 11;
    localparam int unsigned Y_W      = 10;
    localparam int unsigned FC_W     = 16;
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam logic        SYNC_ON  = (SYNC_ACTIVE_HIGH != 0);

    logic [X_W-1:0]  x_q, x_d;
    logic [Y_W-1:0]  y_q, y_d;
    logic            visible_q, visible_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            start_q, start_d;
    logic [FC_W-1:0] frame_q, frame_d;
    logic            x_last;
    logic            y_last;

    // Next position first; flags are decoded from that same next position so every
    // registered output describes one beam location with no relative skew.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        start_d = 1'b0;
        x_last  = (x_q == X_W'(H_TOTAL - 1));
        y_last  = (y_q == Y_W'(V_TOTAL - 1));

        if (pixel_ce_i) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
            end
            start_d = x_last && (y_q == Y_W'(V_VISIBLE - 1));
        end

        frame_d   = frame_q + FC_W'(start_d);
        visible_d = (x_d < X_W'(H_VISIBLE)) && (y_d < Y_W'(V_VISIBLE));
        hsync_d   = ((x_d >= X_W'(HS_START)) && (x_d < X_W'(HS_END))) ? SYNC_ON : ~SYNC_ON;
        vsync_d   = ((y_d >= Y_W'(VS_START)) && (y_d < Y_W'(VS_END))) ? SYNC_ON : ~SYNC_ON;
    end

    // Reset parks the beam on the last position so the first enabled cycle yields (0,0).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q       <= X_W'(H_TOTAL - 1);
            y_q       <= Y_W'(V_TOTAL - 1);
            visible_q <= 1'b0;
            hsync_q   <= ~SYNC_ON;
            vsync_q   <= ~SYNC_ON;
            start_q   <= 1'b0;
            frame_q   <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            visible_q <= visible_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            start_q   <= start_d;
            frame_q   <= frame_d;
        end
    end

    assign x_pixel_o      = x_q;
    assign y_pixel_o      = y_q;
    assign visible_o      = visible_q;
    assign hsync_o        = hsync_q;
    assign vsync_o        = vsync_q;
    assign start_update_o = start_q;
    assign frame_count_o  = frame_q;

endmodule

// File: tb/tb_vga_frame_timing.sv
// Directed bench: a full-size 800x600 instance for line timing, and a shrunken
// active-low-sync instance for frame, clock-enable, reset and counter-wrap behaviour.
module tb_vga_frame_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Full-size instance (default parameters, active-high syncs)
    logic        rst_f, ce_f;
    logic [10:0] x_f;
    logic [9:0]  y_f;
    logic        vis_f, hs_f, vs_f, st_f;
    logic [15:0] fc_f;

    vga_frame_timing u_full (
        .clk_i(clk), .rst_i(rst_f), .pixel_ce_i(ce_f),
        .x_pixel_o(x_f), .y_pixel_o(y_f), .visible_o(vis_f),
        .hsync_o(hs_f), .vsync_o(vs_f), .start_update_o(st_f), .frame_count_o(fc_f)
    );

    // Small instance: H = 8+2+3+2 = 15 (HS 10..12), V = 6+1+2+3 = 12 (VS 7..8), 180 px/frame
    logic        rst_s, ce_s;
    logic [10:0] x_s;
    logic [9:0]  y_s;
    logic        vis_s, hs_s, vs_s, st_s;
    logic [15:0] fc_s;

    vga_frame_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
        .SYNC_ACTIVE_HIGH(0)
    ) u_small (
        .clk_i(clk), .rst_i(rst_s), .pixel_ce_i(ce_s),
        .x_pixel_o(x_s), .y_pixel_o(y_s), .visible_o(vis_s),
        .hsync_o(hs_s), .vsync_o(vs_s), .start_update_o(st_s), .frame_count_o(fc_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int hs_cnt, hs_first, hs_last, early_hs;
    int n_start, st_x, st_y, st_fc, prev_fc, vs_cnt, vs_fx, vs_fy, hs_low;
    int st_width, st_bad_ce, hold_bad;
    int found;
    logic        ce_prev;
    logic [10:0] px;
    logic [9:0]  py;

    initial begin
        rst_f = 1'b1; ce_f = 1'b1;
        rst_s = 1'b1; ce_s = 1'b1;
        tick(); tick();

        // ---------------- full-size instance: reset and one line ----------------
        chk("full_rst_x", 32'(x_f), 32'd1055);
        chk("full_rst_y", 32'(y_f), 32'd627);
        chk("full_rst_vis", 32'(vis_f), 32'd0);
        chk("full_rst_hs", 32'(hs_f), 32'd0);
        chk("full_rst_vs", 32'(vs_f), 32'd0);
        chk("full_rst_fc", 32'(fc_f), 32'd0);

        rst_f = 1'b0;
        tick();
        chk("full_first_x", 32'(x_f), 32'd0);
        chk("full_first_y", 32'(y_f), 32'd0);
        chk("full_first_vis", 32'(vis_f), 32'd1);
        chk("full_first_hsvs", 32'({hs_f, vs_f}), 32'd0);

        early_hs = 0;
        for (int i = 0; i < 799; i++) begin
            tick();
            if (hs_f) early_hs++;
        end
        chk("full_x799", 32'(x_f), 32'd799);
        chk("full_vis799", 32'(vis_f), 32'd1);
        chk("full_hs_in_visible", 32'(early_hs), 32'd0);
        tick();
        chk("full_x800", 32'(x_f), 32'd800);
        chk("full_vis800", 32'(vis_f), 32'd0);

        hs_cnt = 0; hs_first = -1; hs_last = -1;
        for (int i = 0; i < 255; i++) begin
            tick();
            if (hs_f) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(x_f);
                hs_last = int'(x_f);
            end
        end
        chk("full_hs_count", 32'(hs_cnt), 32'd128);
        chk("full_hs_first", 32'(hs_first), 32'd840);
        chk("full_hs_last", 32'(hs_last), 32'd967);
        chk("full_x1055", 32'(x_f), 32'd1055);
        chk("full_vs_line0", 32'(vs_f), 32'd0);
        tick();
        chk("full_wrap_x", 32'(x_f), 32'd0);
        chk("full_wrap_y", 32'(y_f), 32'd1);

        // ---------------- small instance: reset polarity ----------------
        chk("small_rst_x", 32'(x_s), 32'd14);
        chk("small_rst_y", 32'(y_s), 32'd11);
        chk("small_rst_hs_inactive", 32'(hs_s), 32'd1);
        chk("small_rst_vs_inactive", 32'(vs_s), 32'd1);
        chk("small_rst_start", 32'(st_s), 32'd0);

        // ---------------- one full frame at CE=1 ----------------
        rst_s = 1'b0;
        tick();
        chk("small_first_pos", 32'({y_s, x_s}), 32'(0));
        chk("small_first_vis", 32'(vis_s), 32'd1);

        n_start = 0; st_x = -1; st_y = -1; st_fc = -1; prev_fc = int'(fc_s);
        vs_cnt = 0; vs_fx = -1; vs_fy = -1; hs_low = 0;
        for (int i = 0; i < 180; i++) begin
            tick();
            if (st_s) begin
                n_start++;
                st_x = int'(x_s); st_y = int'(y_s); st_fc = int'(fc_s);
                chk("small_fc_before_pulse", 32'(prev_fc), 32'd0);
            end
            if (!vs_s) begin
                vs_cnt++;
                if (vs_fx < 0) begin vs_fx = int'(x_s); vs_fy = int'(y_s); end
            end
            if (!hs_s) hs_low++;
            prev_fc = int'(fc_s);
        end
        chk("small_start_count", 32'(n_start), 32'd1);
        chk("small_start_x", 32'(st_x), 32'd0);
        chk("small_start_y", 32'(st_y), 32'd6);
        chk("small_start_fc", 32'(st_fc), 32'd1);
        chk("small_vs_count", 32'(vs_cnt), 32'd30);
        chk("small_vs_first_x", 32'(vs_fx), 32'd0);
        chk("small_vs_first_y", 32'(vs_fy), 32'd7);
        chk("small_hs_low_count", 32'(hs_low), 32'd36);
        chk("small_frame_end_pos", 32'({y_s, x_s}), 32'(0));

        // ---------------- CE toggling 1,0,1,0: one frame in 360 clocks ----------------
        n_start = 0; st_width = 0; st_bad_ce = 0; hold_bad = 0; st_x = -1; st_y = -1; st_fc = -1;
        for (int i = 0; i < 360; i++) begin
            ce_prev = (i % 2 == 0);
            ce_s = ce_prev;
            px = x_s; py = y_s;
            tick();
            if (st_s) begin
                st_width++;
                if (!ce_prev) st_bad_ce++;
                n_start++;
                st_x = int'(x_s); st_y = int'(y_s); st_fc = int'(fc_s);
            end
            if (!ce_prev && (x_s != px || y_s != py)) hold_bad++;
        end
        chk("ce_start_count", 32'(n_start), 32'd1);
        chk("ce_start_width", 32'(st_width), 32'd1);
        chk("ce_start_on_idle", 32'(st_bad_ce), 32'd0);
        chk("ce_hold_violations", 32'(hold_bad), 32'd0);
        chk("ce_start_pos", 32'({16'(st_y), 16'(st_x)}), {16'd6, 16'd0});
        chk("ce_start_fc", 32'(st_fc), 32'd2);
        chk("ce_frame_end_pos", 32'({y_s, x_s}), 32'(0));

        // ---------------- frame counter wrap ----------------
        ce_s = 1'b0;
        force u_small.frame_q = 16'hFFFF;
        tick();
        release u_small.frame_q;
        tick();
        chk("fc_preload", 32'(fc_s), 32'd65535);
        chk("fc_preload_no_start", 32'(st_s), 32'd0);
        ce_s = 1'b1;
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            tick();
            if (st_s) found = 1;
        end
        chk("fc_wrap_found", 32'(found), 32'd1);
        chk("fc_wrap_value", 32'(fc_s), 32'd0);
        chk("fc_wrap_pos", 32'({y_s, x_s}), 32'({10'd6, 11'd0}));

        // ---------------- async reset right before the would-be strobe ----------------
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            tick();
            if (x_s == 11'd14 && y_s == 10'd5) found = 1;
        end
        chk("mid_reach_14_5", 32'(found), 32'd1);
        chk("mid_fc_before_reset", 32'(fc_s), 32'd0);
        #2;
        rst_s = 1'b1;
        #1;
        chk("mid_async_x", 32'(x_s), 32'd14);
        chk("mid_async_y", 32'(y_s), 32'd11);
        chk("mid_async_vis", 32'(vis_s), 32'd0);
        chk("mid_async_syncs", 32'({hs_s, vs_s}), 32'd3);
        chk("mid_async_fc", 32'(fc_s), 32'd0);
        tick();
        chk("mid_no_start", 32'(st_s), 32'd0);
        chk("mid_hold_fc", 32'(fc_s), 32'd0);
        rst_s = 1'b0;
        tick();
        chk("mid_restart_pos", 32'({y_s, x_s}), 32'(0));
        chk("mid_restart_start", 32'(st_s), 32'd0);
        chk("mid_restart_vis", 32'(vis_s), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
